// File: rtl/mmio_uart_tx_pkg.sv
// Shared register map, status bit positions, shifter states and reset defaults.
package mmio_uart_tx_pkg;

  localparam int unsigned BUS_AW = 2;
  localparam int unsigned BUS_DW = 16;
  localparam int unsigned DIV_W  = 16;

  localparam logic [BUS_AW-1:0] ADDR_DATA   = 2'd0;
  localparam logic [BUS_AW-1:0] ADDR_STATUS = 2'd1;
  localparam logic [BUS_AW-1:0] ADDR_DIV    = 2'd2;

  localparam int unsigned STAT_FULL  = 0;
  localparam int unsigned STAT_EMPTY = 1;
  localparam int unsigned STAT_BUSY  = 2;

  localparam logic [DIV_W-1:0] DIV_RESET_DEFAULT = 16'd868;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// Byte FIFO with an extra pointer bit so full and empty are distinguishable.
module sync_fifo_byte #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] wdata,
  input  logic       pop,
  output logic [7:0] head_c,
  output logic       full_c,
  output logic       empty_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Pointer update; pointers wrap naturally modulo 2*DEPTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign head_c  = mem[rd_ptr[AW-1:0]];
  assign empty_c = (wr_ptr == rd_ptr);
  assign full_c  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bus decode, baud counter and shift FSM.
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter int unsigned      FIFO_DEPTH = 4,
  parameter logic [DIV_W-1:0] DIV_RESET  = DIV_RESET_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bus_req,
  input  logic              bus_we,
  input  logic [BUS_AW-1:0] bus_addr,
  input  logic [BUS_DW-1:0] bus_wdata,
  output logic [BUS_DW-1:0] bus_rdata,
  output logic              bus_ack,
  output logic              tx,
  output logic              irq_empty
);

  tx_state_e        state;
  logic [DIV_W-1:0] div_reg;
  logic [DIV_W-1:0] div_lat;
  logic [DIV_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_byte;

  logic [7:0]        fifo_head_c;
  logic              fifo_full_c;
  logic              fifo_empty_c;
  logic              bit_done_c;
  logic              busy_c;
  logic              pop_c;
  logic              sel_c;
  logic              data_wr_c;
  logic              stall_c;
  logic              accept_c;
  logic              push_c;
  logic [BUS_DW-1:0] rdata_c;

  assign bit_done_c = (baud_cnt == '0);
  assign busy_c     = (state != ST_IDLE);
  assign pop_c      = !fifo_empty_c && ((state == ST_IDLE) || ((state == ST_STOP) && bit_done_c));
  assign sel_c      = bus_req && !bus_ack;
  assign data_wr_c  = sel_c && bus_we && (bus_addr == ADDR_DATA);
  assign stall_c    = data_wr_c && fifo_full_c && !pop_c;
  assign accept_c   = sel_c && !stall_c;
  assign push_c     = data_wr_c && !stall_c;

  sync_fifo_byte #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_c),
    .wdata   (bus_wdata[7:0]),
    .pop     (pop_c),
    .head_c  (fifo_head_c),
    .full_c  (fifo_full_c),
    .empty_c (fifo_empty_c)
  );

  // Load data mux; DATA and the reserved offset read as zero.
  always_comb begin
    rdata_c = '0;
    if (!bus_we) begin
      case (bus_addr)
        ADDR_STATUS: begin
          rdata_c[STAT_FULL]  = fifo_full_c;
          rdata_c[STAT_EMPTY] = fifo_empty_c;
          rdata_c[STAT_BUSY]  = busy_c;
        end
        ADDR_DIV: rdata_c = div_reg;
        default:  rdata_c = '0;
      endcase
    end
  end

  // Bus response and divisor register; a zero divisor is clamped to one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_ack   <= 1'b0;
      bus_rdata <= '0;
      div_reg   <= DIV_RESET;
    end else begin
      bus_ack   <= accept_c;
      bus_rdata <= accept_c ? rdata_c : '0;
      if (accept_c && bus_we && (bus_addr == ADDR_DIV)) begin
        div_reg <= (bus_wdata == '0) ? DIV_W'(1) : bus_wdata;
      end
    end
  end

  // Shift FSM; divisor is captured per frame so mid-frame writes wait a frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      tx         <= 1'b1;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shift_byte <= '0;
      div_lat    <= DIV_RESET;
    end else begin
      case (state)
        ST_IDLE: begin
          tx <= 1'b1;
          if (pop_c) begin
            state      <= ST_START;
            tx         <= 1'b0;
            shift_byte <= fifo_head_c;
            div_lat    <= div_reg;
            baud_cnt   <= div_reg - DIV_W'(1);
          end
        end
        ST_START: begin
          if (bit_done_c) begin
            state    <= ST_DATA;
            bit_idx  <= '0;
            tx       <= shift_byte[0];
            baud_cnt <= div_lat - DIV_W'(1);
          end else begin
            baud_cnt <= baud_cnt - DIV_W'(1);
          end
        end
        ST_DATA: begin
          if (bit_done_c) begin
            baud_cnt <= div_lat - DIV_W'(1);
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift_byte[3'(bit_idx + 3'd1)];
            end
          end else begin
            baud_cnt <= baud_cnt - DIV_W'(1);
          end
        end
        ST_STOP: begin
          if (bit_done_c) begin
            if (pop_c) begin
              state      <= ST_START;
              tx         <= 1'b0;
              shift_byte <= fifo_head_c;
              div_lat    <= div_reg;
              baud_cnt   <= div_reg - DIV_W'(1);
            end else begin
              state <= ST_IDLE;
              tx    <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt - DIV_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

  // Empty interrupt level, one cycle behind the FIFO/FSM state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) irq_empty <= 1'b1;
    else      irq_empty <= fifo_empty_c && !busy_c;
  end

endmodule
